ks_adder_pipe: RTL and testbench

Parametrised, pipelined Kogge-Stone adder: a WIDTH-bit generalisation of the team's fixed 16-bit prefix layers, with one register stage per prefix level and a valid/ready stream interface. It sits in the datapath wherever a high-frequency wide adder is needed. It accepts one operand pair per cycle and returns sum, carry-out and signed overflow after a fixed latency. Backpressure stalls the whole pipeline.

---
 rtl/ks_adder_pkg.sv | 21 ++
 rtl/ks_prefix_level.sv | 27 ++
 rtl/ks_adder_pipe.sv | 113 +++++++++++
 tb/tb_ks_adder_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_adder_pkg.sv
// rtl/ks_adder_pkg.sv - shared constants, helper function and stage record header for ks_adder_pipe
package ks_adder_pkg;

  // Ceiling log2, evaluated at elaboration time to size the prefix tree.
  function automatic int ks_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width-independent part of a pipeline stage record. The user module
  // wraps it with its WIDTH-sized G, P and p_orig vectors.
  typedef struct packed {
    logic valid;
    logic cin;
  } ks_stage_hdr_t;

endpackage

// File: rtl/ks_prefix_level.sv
// rtl/ks_prefix_level.sv - one combinational Kogge-Stone prefix level
//
// Ports:
//   g_in / p_in   : group generate / propagate from the previous level
//   g_out / p_out : combined with the bit DIST positions below
// Bits below DIST have no partner at this level and pass through unchanged.
module ks_prefix_level #(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_op
      assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
      assign p_out[i] = p_in[i] & p_in[i-DIST];
    end else begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// rtl/ks_adder_pipe.sv - pipelined Kogge-Stone adder, one register stage per prefix level
//
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready = global advance)
//   a, b, cin            : operands and carry-in, sampled on transfer only
//   sub                  : subtract select (only when KSA_SUB_EN is defined)
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : a+b+cin mod 2^WIDTH, carry out, signed overflow
// Optional feature macro: KSA_SUB_EN (adds the sub port and b inversion).
// Latency is LEVELS+1 cycles; any output stall freezes every stage.
module ks_adder_pipe
  import ks_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef KSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = ks_clog2(WIDTH);

  typedef struct packed {
    ks_stage_hdr_t    hdr;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p_orig;
  } stage_t;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  stage_t           gp_d;
  stage_t           stage_q [LEVELS+1];
  logic [WIDTH-1:0] g_nx [1:LEVELS];
  logic [WIDTH-1:0] p_nx [1:LEVELS];
  logic [WIDTH-1:0] carry_in;

`ifdef KSA_SUB_EN
  // a - b = a + ~b + 1; the caller's cin is ignored while subtracting.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // A stalled output blocks the whole pipe; no bubble collapsing.
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  // Stage 0: bitwise generate/propagate, carry-in folded into g[0] so that
  // the final G[i] is the true carry out of bit i.
  always_comb begin
    gp_d           = '0;
    gp_d.hdr.valid = in_valid;
    gp_d.hdr.cin   = cin_eff;
    gp_d.p         = a ^ b_eff;
    gp_d.p_orig    = a ^ b_eff;
    gp_d.g         = a & b_eff;
    gp_d.g[0]      = (a[0] & b_eff[0]) | ((a[0] ^ b_eff[0]) & cin_eff);
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    ks_prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << (k - 1))
    ) u_level (
      .g_in  (stage_q[k-1].g),
      .p_in  (stage_q[k-1].p),
      .g_out (g_nx[k]),
      .p_out (p_nx[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LEVELS; k++) begin
        stage_q[k] <= '0;
      end
    end else if (advance) begin
      stage_q[0] <= gp_d;
      for (int k = 1; k <= LEVELS; k++) begin
        stage_q[k].hdr    <= stage_q[k-1].hdr;
        stage_q[k].p_orig <= stage_q[k-1].p_orig;
        stage_q[k].g      <= g_nx[k];
        stage_q[k].p      <= p_nx[k];
      end
    end
  end

  // Output decode straight from the last register: carry into bit i is the
  // prefix carry out of bit i-1, bit 0 takes the carried-along cin.
  assign carry_in  = {stage_q[LEVELS].g[WIDTH-2:0], stage_q[LEVELS].hdr.cin};
  assign sum       = stage_q[LEVELS].p_orig ^ carry_in;
  assign cout      = stage_q[LEVELS].g[WIDTH-1];
  assign ovf       = stage_q[LEVELS].g[WIDTH-1] ^ stage_q[LEVELS].g[WIDTH-2];
  assign out_valid = stage_q[LEVELS].hdr.valid;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb/tb_ks_adder_pipe.sv - directed self-checking bench for ks_adder_pipe (WIDTH=16)
module tb_ks_adder_pipe;

  localparam int W = 16;

  typedef struct packed {
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  typedef struct packed {
    logic         cout;
    logic         ovf;
    logic [W-1:0] sum;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef KSA_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   delivered = 0;
  int   first_out = -1;
  int   last_out  = -1;
  vec_t in_q[$];
  res_t exp_q[$];

  always #5 clk = ~clk;

  ks_adder_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef KSA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  function automatic vec_t mk(logic [W-1:0] va, logic [W-1:0] vb, logic vc, logic vs);
    vec_t v;
    v.a   = va;
    v.b   = vb;
    v.cin = vc;
    v.sub = vs;
    return v;
  endfunction

  // Arithmetic reference: plain wide addition, signed overflow from operand signs.
  function automatic res_t model(vec_t v);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   s;
    res_t         r;
    bb     = v.sub ? ~v.b : v.b;
    cc     = v.sub ? 1'b1 : v.cin;
    s      = {1'b0, v.a} + {1'b0, bb} + {{W{1'b0}}, cc};
    r.sum  = s[W-1:0];
    r.cout = s[W];
    r.ovf  = (v.a[W-1] == bb[W-1]) && (s[W-1] != v.a[W-1]);
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(vec_t v, logic vld);
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    in_valid = vld;
`ifdef KSA_SUB_EN
    sub      = v.sub;
`endif
  endtask

  // One cycle: present queued input, score any output handshake, record any
  // input handshake, then move to the next falling edge.
  task automatic step();
    vec_t v;
    res_t r;
    if (in_q.size() != 0) drive(in_q[0], 1'b1);
    else                  drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
    #1;
    if (out_valid && out_ready) begin
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("stream_result", 32'({cout, ovf, sum}), 32'(r));
        delivered++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end
    if (in_valid && in_ready) begin
      v = in_q.pop_front();
      exp_q.push_back(model(v));
    end
    @(negedge clk);
    cyc++;
  endtask

  // Single transaction into an empty pipe, checked against hand-computed values.
  task automatic directed(string tag, vec_t v, logic [W-1:0] es, logic ec, logic eo);
    int n;
    out_ready = 1'b1;
    drive(v, 1'b1);
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd5);
    chk({tag, "_sum"},  32'(sum),  32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"},  32'(ovf),  32'(eo));
    @(negedge clk);
    chk({tag, "_single"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int   n;
    int   stale;
    res_t held;

    rst       = 1'b1;
    out_ready = 1'b1;
    drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_outputs",   32'({cout, ovf, sum}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    directed("wrap",     mk(16'hFFFF, 16'h0001, 1'b0, 1'b0), 16'h0000, 1'b1, 1'b0);
    directed("pos_ovf",  mk(16'h7FFF, 16'h0001, 1'b0, 1'b0), 16'h8000, 1'b0, 1'b1);
    directed("cin_in",   mk(16'h00FF, 16'h0000, 1'b1, 1'b0), 16'h0100, 1'b0, 1'b0);
    directed("neg_ovf",  mk(16'h8000, 16'h8000, 1'b0, 1'b0), 16'h0000, 1'b1, 1'b1);
    directed("full_chain", mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0), 16'hFFFF, 1'b1, 1'b0);

    // Eight back-to-back transfers must come out on eight consecutive cycles.
    for (int i = 0; i < 8; i++) in_q.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), 1'b0));
    delivered = 0;
    first_out = -1;
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < 40) begin
      step();
      n++;
    end
    chk("b2b_count", 32'(delivered), 32'd8);
    chk("b2b_consecutive", 32'(last_out - first_out), 32'd7);

    // Fill the pipe with the output blocked, hold, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) in_q.push_back(mk(W'($urandom), W'($urandom), 1'($urandom), 1'b0));
    delivered = 0;
    repeat (7) step();
    chk("stall_accepted", 32'(in_q.size()), 32'd1);
    held = {cout, ovf, sum};
    chk("stall_head", 32'(held), 32'(exp_q[0]));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_hold",      32'({cout, ovf, sum}), 32'(held));
    end
    out_ready = 1'b1;
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < 30) begin
      step();
      n++;
    end
    chk("release_count", 32'(delivered), 32'd6);
    stale = 0;
    repeat (3) begin
      #1;
      if (out_valid) stale++;
      @(negedge clk);
    end
    chk("release_no_dup", 32'(stale), 32'd0);

    // Reset with three transactions in flight discards them all.
    for (int i = 0; i < 3; i++) in_q.push_back(mk(W'($urandom), W'($urandom), 1'b0, 1'b0));
    repeat (3) step();
    chk("rst_inflight", 32'(exp_q.size()), 32'd3);
    rst = 1'b1;
    drive(mk('0, '0, 1'b0, 1'b0), 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    exp_q.delete();
    in_q.delete();
    stale = 0;
    repeat (10) begin
      if (out_valid) stale++;
      @(negedge clk);
      #1;
    end
    chk("midrst_no_stale", 32'(stale), 32'd0);
    @(negedge clk);
    directed("post_rst", mk(16'h1234, 16'h4321, 1'b1, 1'b0), 16'h5556, 1'b0, 1'b0);

`ifdef KSA_SUB_EN
    directed("sub_borrow", mk(16'h0005, 16'h0007, 1'b1, 1'b1), 16'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf",    mk(16'h8000, 16'h0001, 1'b0, 1'b1), 16'h7FFF, 1'b1, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
